// File: rtl/ysyx_l1i_cache.sv
// Direct-mapped L1 instruction cache between the IFU fetch stage and the instruction bus.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pc_i, req_i       fetch address (word aligned) and fetch request
//   invalidate_i      fence.i: invalidate every line
//   hit_o, inst_o     combinational hit and instruction for pc_i (inst_o = 0 on miss)
//   busy_o            refill in progress
//   araddr_o, arvalid_o, arlen_o, arready_i   bus read-address channel
//   rdata_i, rvalid_i                          bus read-data channel
module ysyx_l1i_cache #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     SET_LEN     = 2,
  parameter int unsigned     LINE_LEN    = 1,
  parameter logic [XLEN-1:0] BURST_BASE  = 'ha0000000,
  parameter logic [XLEN-1:0] BURST_LIMIT = 'hc0000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            req_i,
  input  logic            invalidate_i,
  output logic            hit_o,
  output logic [31:0]     inst_o,
  output logic            busy_o,
  output logic [XLEN-1:0] araddr_o,
  output logic            arvalid_o,
  output logic [7:0]      arlen_o,
  input  logic            arready_i,
  input  logic [31:0]     rdata_i,
  input  logic            rvalid_i
);

  localparam int unsigned SETS    = 1 << SET_LEN;
  localparam int unsigned WORDS   = 1 << LINE_LEN;
  localparam int unsigned OFF_W   = (LINE_LEN == 0) ? 1 : LINE_LEN;
  localparam int unsigned IDX_LSB = LINE_LEN + 2;
  localparam int unsigned TAG_LSB = SET_LEN + LINE_LEN + 2;
  localparam int unsigned TAG_W   = XLEN - TAG_LSB;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);
  localparam logic [7:0]       BURST_LEN = 8'(WORDS - 1);
  localparam logic [XLEN-1:0]  LINE_MASK = ~((XLEN'(1) << IDX_LSB) - XLEN'(1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_DONE
  } state_t;

  // Address field extraction
  function automatic logic [SET_LEN-1:0] idx_of(input logic [XLEN-1:0] a);
    return SET_LEN'(a >> IDX_LSB);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [XLEN-1:0] a);
    return TAG_W'(a >> TAG_LSB);
  endfunction

  function automatic logic [OFF_W-1:0] off_of(input logic [XLEN-1:0] a);
    if (LINE_LEN == 0) return '0;
    return OFF_W'(a >> 2);
  endfunction

  state_t state_q, state_d;

  logic [31:0]      data_q [SETS][WORDS];
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [SETS-1:0]  valid_q;

  logic [XLEN-1:0]  line_addr_q;
  logic             burst_q;
  logic [OFF_W-1:0] beat_q;
  logic             flush_pending_q;

  logic [SET_LEN-1:0] pc_idx_c;
  logic [TAG_W-1:0]   pc_tag_c;
  logic [OFF_W-1:0]   pc_off_c;
  logic [XLEN-1:0]    pc_line_c;
  logic [SET_LEN-1:0] line_idx_c;
  logic [TAG_W-1:0]   line_tag_c;
  logic               miss_start_c;
  logic               fill_beat_c;
  logic               flush_now_c;
  logic               unused_pc_lsb;

  assign pc_idx_c     = idx_of(pc_i);
  assign pc_tag_c     = tag_of(pc_i);
  assign pc_off_c     = off_of(pc_i);
  assign pc_line_c    = pc_i & LINE_MASK;
  assign line_idx_c   = idx_of(line_addr_q);
  assign line_tag_c   = tag_of(line_addr_q);
  assign unused_pc_lsb = ^pc_i[1:0];

  // Zero-latency lookup; fence.i in IDLE masks the hit for that cycle
  assign hit_o  = (state_q == S_IDLE) && req_i && !invalidate_i &&
                  valid_q[pc_idx_c] && (tag_q[pc_idx_c] == pc_tag_c);
  assign inst_o = hit_o ? data_q[pc_idx_c][pc_off_c] : 32'd0;

  assign miss_start_c = (state_q == S_IDLE) && req_i && !hit_o && !invalidate_i;
  assign fill_beat_c  = (state_q == S_FILL) && rvalid_i;
  // A fence.i seen at any point of the refill (including DONE) discards the whole cache
  assign flush_now_c  = flush_pending_q || invalidate_i;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and bus-facing outputs
  always_comb begin
    state_d   = state_q;
    busy_o    = 1'b0;
    arvalid_o = 1'b0;
    araddr_o  = '0;
    arlen_o   = 8'd0;
    unique case (state_q)
      S_IDLE: begin
        if (miss_start_c) state_d = S_REQ;
      end
      S_REQ: begin
        busy_o    = 1'b1;
        arvalid_o = 1'b1;
        araddr_o  = line_addr_q + (XLEN'(beat_q) << 2);
        arlen_o   = burst_q ? BURST_LEN : 8'd0;
        if (arready_i) state_d = S_FILL;
      end
      S_FILL: begin
        busy_o = 1'b1;
        if (rvalid_i) begin
          if (beat_q == LAST_BEAT) state_d = S_DONE;
          else if (!burst_q)       state_d = S_REQ;
        end
      end
      S_DONE: begin
        busy_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Refill bookkeeping and valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q         <= '0;
      flush_pending_q <= 1'b0;
      beat_q          <= '0;
      line_addr_q     <= '0;
      burst_q         <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (invalidate_i) begin
            valid_q <= '0;
          end else if (miss_start_c) begin
            line_addr_q <= pc_line_c;
            burst_q     <= (pc_line_c >= BURST_BASE) && (pc_line_c <= BURST_LIMIT);
            beat_q      <= '0;
          end
        end
        S_REQ: begin
          if (invalidate_i) flush_pending_q <= 1'b1;
        end
        S_FILL: begin
          if (invalidate_i) flush_pending_q <= 1'b1;
          if (rvalid_i)     beat_q <= beat_q + OFF_W'(1);
        end
        S_DONE: begin
          if (flush_now_c) begin
            valid_q         <= '0;
            flush_pending_q <= 1'b0;
          end else begin
            valid_q[line_idx_c] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag storage, not reset
  always_ff @(posedge clk) begin
    if (!rst && fill_beat_c) data_q[line_idx_c][beat_q] <= rdata_i;
    if (!rst && (state_q == S_DONE) && !flush_now_c) tag_q[line_idx_c] <= line_tag_c;
  end

endmodule
